and2_arbiter: RTL and testbench

Round-robin controller that shares one registered `and2` datapath among `NUM_REQ` requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester at a time, drives the datapath operands and holds them stable, waits the datapath latency, captures the result, and returns it with the requester ID on a shared response channel. It sits between requester logic and the `and2` instance and also sequences that instance's active-high reset.

---
 rtl/and2_arbiter.sv | 163 ++++++++++++++++
 tb/tb_and2_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/and2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : and2_arbiter
// Description : Round-robin controller sharing one registered and2 datapath
//               among NUM_REQ requesters. Grants one requester at a time,
//               holds the datapath operands stable for LATENCY edges, captures
//               the result and returns it with the requester ID. Also
//               sequences the datapath's active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module and2_arbiter #(
    parameter int WIDTH   = 2,
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_c,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           dp_a,
    output logic [WIDTH-1:0]           dp_b,
    output logic                       dp_reset,
    input  logic [WIDTH-1:0]           dp_c,
    output logic [15:0]                ops_done
);

    localparam int                ID_W      = $clog2(NUM_REQ);
    localparam int                CNT_W     = 3;
    localparam logic [ID_W-1:0]   C_LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]  C_LAT     = CNT_W'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  dp_a_q;
    logic [WIDTH-1:0]  dp_b_q;
    logic [WIDTH-1:0]  rsp_c_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_valid_q;
    logic [15:0]       ops_done_q;
    logic              dp_ok_q;
    logic              dp_reset_q;

    logic              grant_vld_d;
    logic [ID_W-1:0]   grant_id_d;
    logic [WIDTH-1:0]  sel_a_d;
    logic [WIDTH-1:0]  sel_b_d;
    logic              accept_d;

    // Round-robin search: first valid requester after rr_ptr, wrapping modulo NUM_REQ.
    // Scanning from the farthest offset down lets the nearest match win.
    always_comb begin : p_grant
        int idx;
        grant_vld_d = 1'b0;
        grant_id_d  = '0;
        idx         = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid[ID_W'(idx)]) begin
                grant_vld_d = 1'b1;
                grant_id_d  = ID_W'(idx);
            end
        end
    end

    // Operand mux selecting the granted requester's slices.
    always_comb begin : p_sel
        sel_a_d = '0;
        sel_b_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_d == ID_W'(i)) begin
                sel_a_d = req_a[i*WIDTH +: WIDTH];
                sel_b_d = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept only when idle and the datapath has had a cycle out of reset.
    assign accept_d = (state_q == S_IDLE) && dp_ok_q && grant_vld_d;

    // One-hot ready toward the granted requester during an accept cycle.
    always_comb begin : p_ready
        req_ready = '0;
        if (accept_d) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (grant_id_d == ID_W'(i));
            end
        end
    end

    // Controller FSM with registered datapath operands, response and counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= C_LAST_ID;
            cnt_q       <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            rsp_c_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            ops_done_q  <= '0;
            dp_ok_q     <= 1'b0;
            dp_reset_q  <= 1'b1;
        end else begin
            dp_reset_q <= 1'b0;
            dp_ok_q    <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        dp_a_q   <= sel_a_d;
                        dp_b_q   <= sel_b_d;
                        rsp_id_q <= grant_id_d;
                        rr_ptr_q <= grant_id_d;
                        cnt_q    <= C_LAT;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        rsp_c_q     <= dp_c;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ops_done_q  <= ops_done_q + 16'd1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_id    = rsp_id_q;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_reset  = dp_reset_q;
    assign ops_done  = ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_and2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_and2_arbiter
// Description : Self-checking bench for and2_arbiter. Random requesters drive
//               a LATENCY=1 instance scored against a transaction-level model;
//               a LATENCY=3 instance checks response timing and operand hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_and2_arbiter;

    localparam int W    = 2;
    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- main instance (LATENCY = 1) ----------------
    logic           reset;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [W-1:0]   rsp_c, dp_a, dp_b, dp_c;
    logic [IDW-1:0] rsp_id;
    logic           dp_reset;
    logic [15:0]    ops_done;

    and2_arbiter #(.WIDTH(W), .NUM_REQ(N), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_id(rsp_id),
        .dp_a(dp_a), .dp_b(dp_b), .dp_reset(dp_reset), .dp_c(dp_c),
        .ops_done(ops_done)
    );

    // Registered and2 datapath with LAT pipeline stages
    logic [W-1:0] pipe1 [LAT];
    always @(posedge clk) begin
        if (dp_reset) begin
            for (int k = 0; k < LAT; k++) pipe1[k] <= '0;
        end else begin
            pipe1[0] <= dp_a & dp_b;
            for (int k = 1; k < LAT; k++) pipe1[k] <= pipe1[k-1];
        end
    end
    assign dp_c = pipe1[LAT-1];

    // ---------------- second instance (LATENCY = 3) ----------------
    logic [N-1:0]   req_valid_3, req_ready_3;
    logic [N*W-1:0] req_a_3, req_b_3;
    logic           rsp_valid_3;
    logic           rsp_ready_3;
    logic [W-1:0]   rsp_c_3, dp_a_3, dp_b_3, dp_c_3;
    logic [IDW-1:0] rsp_id_3;
    logic           dp_reset_3;
    logic [15:0]    ops_done_3;

    and2_arbiter #(.WIDTH(W), .NUM_REQ(N), .LATENCY(LAT3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_3), .req_ready(req_ready_3),
        .req_a(req_a_3), .req_b(req_b_3),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3),
        .rsp_c(rsp_c_3), .rsp_id(rsp_id_3),
        .dp_a(dp_a_3), .dp_b(dp_b_3), .dp_reset(dp_reset_3), .dp_c(dp_c_3),
        .ops_done(ops_done_3)
    );

    logic [W-1:0] pipe3 [LAT3];
    always @(posedge clk) begin
        if (dp_reset_3) begin
            for (int k = 0; k < LAT3; k++) pipe3[k] <= '0;
        end else begin
            pipe3[0] <= dp_a_3 & dp_b_3;
            for (int k = 1; k < LAT3; k++) pipe3[k] <= pipe3[k-1];
        end
    end
    assign dp_c_3 = pipe3[LAT3-1];

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard + reference model ----------------
    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;
    exp_t sb[$];

    bit m_seen_rst  = 1'b0;  // a reset edge has occurred
    bit m_last_rst  = 1'b0;  // reset level at the most recent edge
    bit m_busy      = 1'b0;  // a request is accepted and its response not yet taken
    int m_ptr       = N - 1; // last granted requester
    int m_rsp_edge  = 0;     // edge after which the response must be visible
    int m_ready_edg = 0;     // earliest edge at which a new accept may happen
    int m_ops       = 0;     // completed handshakes
    int m_grant;
    bit m_exp_rv;

    // Monitor: at each falling edge compare DUT outputs with the model, then
    // advance the model to what the coming rising edge must do.
    initial begin : monitor
        forever begin
            @(negedge clk);
            m_grant  = -1;
            m_exp_rv = 1'b0;
            if (m_seen_rst) begin
                m_exp_rv = m_busy && (cyc >= m_rsp_edge);
                check("dp_reset", dp_reset, !m_last_rst);
                check("ops_done", ops_done, m_ops & 32'hFFFF);
                check("rsp_valid", rsp_valid, m_exp_rv);
                if (m_busy) begin
                    check("dp_a_hold", dp_a, sb[0].a);
                    check("dp_b_hold", dp_b, sb[0].b);
                end
                if (m_exp_rv) begin
                    check("rsp_id", rsp_id, sb[0].id);
                    check("rsp_c", rsp_c, sb[0].a & sb[0].b);
                end
                if (!m_busy && (cyc + 1 >= m_ready_edg)) begin
                    for (int k = 1; k <= N; k++) begin
                        if (m_grant < 0 && req_valid[IDW'((m_ptr + k) % N)])
                            m_grant = (m_ptr + k) % N;
                    end
                end
                check("req_ready", req_ready, (m_grant >= 0) ? (32'd1 << m_grant) : 32'd0);
            end
            if (!reset) begin
                m_seen_rst  = 1'b1;
                m_busy      = 1'b0;
                sb.delete();
                m_ptr       = N - 1;
                m_ops       = 0;
                m_ready_edg = cyc + 3;
            end else if (m_seen_rst) begin
                if (m_grant >= 0) begin
                    sb.push_back('{m_grant, W'(req_a >> (m_grant * W)), W'(req_b >> (m_grant * W))});
                    m_busy     = 1'b1;
                    m_rsp_edge = cyc + 1 + LAT + 1;
                    m_ptr      = m_grant;
                end else if (m_exp_rv && rsp_ready) begin
                    void'(sb.pop_front());
                    m_busy      = 1'b0;
                    m_ops       = m_ops + 1;
                    m_ready_edg = cyc + 2;
                end
            end
            m_last_rst = reset;
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] mask;
    int p_raise, p_drop, p_rdy;

    // One cycle of requester behaviour: accepted or idle requesters may raise a
    // fresh request; pending ones hold or occasionally withdraw.
    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[IDW'(i)] || !req_valid[IDW'(i)]) begin
                req_valid[IDW'(i)] = mask[IDW'(i)] && ($urandom_range(99) < p_raise);
                req_a[i*W +: W] = W'($urandom);
                req_b[i*W +: W] = W'($urandom);
            end else if ($urandom_range(99) < p_drop) begin
                req_valid[IDW'(i)] = 1'b0;
            end
        end
        rsp_ready = ($urandom_range(99) < p_rdy);
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit           found;
        logic [W-1:0] a3, b3;
        int           acc_edge;

        // Reset held 5 cycles with every requester valid
        reset       = 1'b0;
        req_valid   = '1;
        req_a       = {W'(0), W'(1), W'(2), W'(3)};
        req_b       = '1;
        rsp_ready   = 1'b1;
        req_valid_3 = '0;
        req_a_3     = '0;
        req_b_3     = '0;
        rsp_ready_3 = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Release with only requester 2 asking; abort its operation in WAIT
        reset     = 1'b1;
        req_valid = 4'b0100;
        req_a     = {W'(0), 2'b11, W'(0), W'(0)};
        req_b     = {W'(0), 2'b10, W'(0), W'(0)};
        found     = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (req_ready[2] && req_valid[2]) found = 1'b1;
            @(posedge clk);
            #1;
        end
        check("abort_accept_seen", found, 1);
        reset     = 1'b0;
        req_valid = '1;
        req_a     = {2'b11, 2'b01, 2'b10, 2'b11};
        req_b     = {2'b01, 2'b11, 2'b11, 2'b10};
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Round-robin with all requesters continuously valid
        mask = '1; p_raise = 100; p_drop = 0; p_rdy = 100;
        run(40);

        // Drain, then a single directed op from requester 2
        mask = '0;
        run(8);
        req_valid = 4'b0100;
        req_a     = {W'(0), 2'b11, W'(0), W'(0)};
        req_b     = {W'(0), 2'b10, W'(0), W'(0)};
        mask = 4'b0100; p_raise = 0;
        run(8);

        // Backpressure: response consumer stalled, then released
        mask = '1; p_raise = 100; p_rdy = 0;
        run(15);
        p_rdy = 100;
        run(10);

        // Random traffic with withdrawals and random backpressure
        p_raise = 40; p_drop = 10; p_rdy = 60;
        run(400);
        mask = '0; p_rdy = 100;
        run(10);

        // LATENCY=3 instance: response 4 cycles after accept, operands held
        for (int n = 0; n < 6; n++) begin
            a3 = W'($urandom);
            b3 = W'($urandom);
            req_a_3 = {W'(0), W'(0), a3, W'(0)};
            req_b_3 = {W'(0), W'(0), b3, W'(0)};
            req_valid_3 = 4'b0010;
            found    = 1'b0;
            acc_edge = 0;
            for (int t = 0; t < 20 && !found; t++) begin
                @(negedge clk);
                if (req_ready_3[1]) begin
                    found    = 1'b1;
                    acc_edge = cyc + 1;
                end
            end
            check("lat3_accept", found, 1);
            @(posedge clk);
            #1;
            req_valid_3 = '0;
            found = 1'b0;
            for (int t = 0; t < 20 && !found; t++) begin
                @(negedge clk);
                if (rsp_valid_3) begin
                    found = 1'b1;
                    check("lat3_latency", cyc - acc_edge, LAT3 + 1);
                    check("lat3_rsp_c", rsp_c_3, a3 & b3);
                    check("lat3_rsp_id", rsp_id_3, 1);
                end else begin
                    check("lat3_dp_a_hold", dp_a_3, a3);
                    check("lat3_dp_b_hold", dp_b_3, b3);
                end
            end
            check("lat3_rsp_seen", found, 1);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
